cmd_file_loader: RTL

- Upstream of the Z80 register-set stage. Parses a TRS-80 /CMD image arriving on the MiSTer ioctl download stream and writes load-block bytes to system RAM.
- Captures the transfer (entry) address and, once the download ends, pulses execute_enable with execute_addr and execute_method. The register-set stage then loads PC/SP into the T80.

---
 rtl/cmd_file_loader_if.sv | 44 ++++
 rtl/cmd_file_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_file_loader_if.sv
// Bus bundle for cmd_file_loader: ioctl download side, RAM write side and
// execute request side. The slave modport is the loader's view.
// Optional CMD_LOADER_RANGE_EN adds the load_lo/load_hi range outputs.
interface cmd_file_loader_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_data;
    logic        autorun;
    logic [1:0]  method_sel;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_wr;
    logic [15:0] execute_addr;
    logic        execute_enable;
    logic [1:0]  execute_method;
    logic        loader_busy;
    logic        load_error;
`ifdef CMD_LOADER_RANGE_EN
    logic [15:0] load_lo;
    logic [15:0] load_hi;

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_data, autorun, method_sel,
        output mem_addr, mem_data, mem_wr, execute_addr, execute_enable,
               execute_method, loader_busy, load_error, load_lo, load_hi
    );
    modport master (
        output ioctl_download, ioctl_wr, ioctl_data, autorun, method_sel,
        input  mem_addr, mem_data, mem_wr, execute_addr, execute_enable,
               execute_method, loader_busy, load_error, load_lo, load_hi
    );
`else
    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_data, autorun, method_sel,
        output mem_addr, mem_data, mem_wr, execute_addr, execute_enable,
               execute_method, loader_busy, load_error
    );
    modport master (
        output ioctl_download, ioctl_wr, ioctl_data, autorun, method_sel,
        input  mem_addr, mem_data, mem_wr, execute_addr, execute_enable,
               execute_method, loader_busy, load_error
    );
`endif
endinterface

// File: rtl/cmd_file_loader.sv
// TRS-80 /CMD image loader. Parses the ioctl download stream, writes load
// block bytes to RAM, captures the transfer address and issues a timed
// execute request when the download ends cleanly.
// Optional macro CMD_LOADER_RANGE_EN: track min/max written address.
module cmd_file_loader #(
    parameter int PULSE_LEN = 16,
    parameter int MAX_SKIP  = 256
) (
    input logic              clk_sys,
    input logic              reset,
    cmd_file_loader_if.slave bus
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_TYPE  = 4'd1;
    localparam logic [3:0] S_LEN1  = 4'd2;
    localparam logic [3:0] S_ALO   = 4'd3;
    localparam logic [3:0] S_AHI   = 4'd4;
    localparam logic [3:0] S_DATA  = 4'd5;
    localparam logic [3:0] S_LEN2  = 4'd6;
    localparam logic [3:0] S_XLO   = 4'd7;
    localparam logic [3:0] S_XHI   = 4'd8;
    localparam logic [3:0] S_DONE  = 4'd9;
    localparam logic [3:0] S_LENS  = 4'd10;
    localparam logic [3:0] S_SKIP  = 4'd11;
    localparam logic [3:0] S_ERROR = 4'd12;

    logic [3:0]  state_q, state_d, cur_state;
    logic        dl_q, dl_d;
    logic        autorun_q, autorun_d;
    logic [1:0]  method_q, method_d;
    logic        xfer_seen_q, xfer_seen_d;
    logic        load_error_q, load_error_d;
    logic [8:0]  count_q, count_d;
    logic [7:0]  tmp_q, tmp_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] xaddr_q, xaddr_d;
    logic        mem_wr_q, mem_wr_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_data_q, mem_data_d;
    logic        exec_en_q, exec_en_d;
    logic [7:0]  pulse_cnt_q, pulse_cnt_d;
    logic        rise, fall;
    logic [8:0]  skip_len;
    logic [7:0]  din;
`ifdef CMD_LOADER_RANGE_EN
    logic [15:0] lo_q, lo_d, hi_q, hi_d;
`endif

    assign din = bus.ioctl_data;

    // Record parser, download edge handling and execute pulse timer
    always_comb begin
        rise         = bus.ioctl_download & ~dl_q;
        fall         = ~bus.ioctl_download & dl_q;
        // A byte on the same cycle as the download start is the record type
        cur_state    = rise ? S_TYPE : state_q;
        state_d      = state_q;
        dl_d         = bus.ioctl_download;
        autorun_d    = autorun_q;
        method_d     = method_q;
        xfer_seen_d  = xfer_seen_q;
        load_error_d = load_error_q;
        count_d      = count_q;
        tmp_d        = tmp_q;
        addr_d       = addr_q;
        xaddr_d      = xaddr_q;
        mem_wr_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        exec_en_d    = exec_en_q;
        pulse_cnt_d  = pulse_cnt_q;
        skip_len     = (din == 8'd0) ? 9'd256 : {1'b0, din};
`ifdef CMD_LOADER_RANGE_EN
        lo_d         = lo_q;
        hi_d         = hi_q;
`endif

        if (exec_en_q) begin
            if (pulse_cnt_q == 8'd0) exec_en_d = 1'b0;
            else                     pulse_cnt_d = pulse_cnt_q - 8'd1;
        end

        if (rise) begin
            load_error_d = 1'b0;
            xfer_seen_d  = 1'b0;
            autorun_d    = bus.autorun;
            method_d     = bus.method_sel;
            state_d      = S_TYPE;
            exec_en_d    = 1'b0;
            pulse_cnt_d  = 8'd0;
`ifdef CMD_LOADER_RANGE_EN
            lo_d         = 16'hFFFF;
            hi_d         = 16'h0000;
`endif
        end

        if (bus.ioctl_download && bus.ioctl_wr) begin
            case (cur_state)
                S_TYPE: begin
                    if (din == 8'h01)      state_d = S_LEN1;
                    else if (din == 8'h02) state_d = S_LEN2;
                    else                   state_d = S_LENS;
                end
                S_LEN1: begin
                    // Length covers the two address bytes; 0..2 wrap to 254..256
                    count_d = (din >= 8'd3) ? ({1'b0, din} - 9'd2) : ({1'b0, din} + 9'd254);
                    state_d = S_ALO;
                end
                S_ALO: begin
                    tmp_d   = din;
                    state_d = S_AHI;
                end
                S_AHI: begin
                    addr_d  = {din, tmp_q};
                    state_d = S_DATA;
                end
                S_DATA: begin
                    mem_wr_d   = 1'b1;
                    mem_addr_d = addr_q;
                    mem_data_d = din;
                    addr_d     = addr_q + 16'd1;
`ifdef CMD_LOADER_RANGE_EN
                    if (addr_q < lo_q) lo_d = addr_q;
                    if (addr_q > hi_q) hi_d = addr_q;
`endif
                    if (count_q == 9'd1) state_d = S_TYPE;
                    else                 count_d = count_q - 9'd1;
                end
                S_LEN2: state_d = S_XLO;
                S_XLO: begin
                    tmp_d   = din;
                    state_d = S_XHI;
                end
                S_XHI: begin
                    xaddr_d     = {din, tmp_q};
                    xfer_seen_d = 1'b1;
                    state_d     = S_DONE;
                end
                S_LENS: begin
                    if (int'(skip_len) > MAX_SKIP) begin
                        load_error_d = 1'b1;
                        state_d      = S_ERROR;
                    end else begin
                        count_d = skip_len;
                        state_d = S_SKIP;
                    end
                end
                S_SKIP: begin
                    if (count_q == 9'd1) state_d = S_TYPE;
                    else                 count_d = count_q - 9'd1;
                end
                default: ;
            endcase
        end

        if (fall) begin
            // Only a record boundary is a legal end of file
            if (state_q != S_DONE && state_q != S_TYPE) begin
                load_error_d = 1'b1;
            end else if (xfer_seen_q && !load_error_q && autorun_q) begin
                exec_en_d   = 1'b1;
                pulse_cnt_d = 8'(PULSE_LEN - 1);
            end
            state_d = S_IDLE;
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            dl_q         <= 1'b0;
            autorun_q    <= 1'b0;
            method_q     <= 2'b00;
            xfer_seen_q  <= 1'b0;
            load_error_q <= 1'b0;
            count_q      <= 9'd0;
            tmp_q        <= 8'd0;
            addr_q       <= 16'h0000;
            xaddr_q      <= 16'h0000;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= 16'h0000;
            mem_data_q   <= 8'd0;
            exec_en_q    <= 1'b0;
            pulse_cnt_q  <= 8'd0;
`ifdef CMD_LOADER_RANGE_EN
            lo_q         <= 16'hFFFF;
            hi_q         <= 16'h0000;
`endif
        end else begin
            state_q      <= state_d;
            dl_q         <= dl_d;
            autorun_q    <= autorun_d;
            method_q     <= method_d;
            xfer_seen_q  <= xfer_seen_d;
            load_error_q <= load_error_d;
            count_q      <= count_d;
            tmp_q        <= tmp_d;
            addr_q       <= addr_d;
            xaddr_q      <= xaddr_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            exec_en_q    <= exec_en_d;
            pulse_cnt_q  <= pulse_cnt_d;
`ifdef CMD_LOADER_RANGE_EN
            lo_q         <= lo_d;
            hi_q         <= hi_d;
`endif
        end
    end

    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_data       = mem_data_q;
    assign bus.mem_wr         = mem_wr_q;
    assign bus.execute_addr   = xaddr_q;
    assign bus.execute_enable = exec_en_q;
    assign bus.execute_method = method_q;
    assign bus.loader_busy    = dl_q;
    assign bus.load_error     = load_error_q;
`ifdef CMD_LOADER_RANGE_EN
    assign bus.load_lo        = lo_q;
    assign bus.load_hi        = hi_q;
`endif

endmodule
